// File: rtl/hilo_pkg.sv
// rtl/hilo_pkg.sv - op encodings and sequencer state for hilo_unit
package hilo_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_MFHI  = 3'd6,
    OP_MFLO  = 3'd7
  } op_e;

`ifdef HILO_MUL_EN
  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_DIV_LAUNCH = 2'd1,
    ST_DIV_WAIT   = 2'd2,
    ST_MUL        = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_DIV_LAUNCH = 2'd1,
    ST_DIV_WAIT   = 2'd2
  } state_e;
`endif

endpackage

// File: rtl/hilo_if.sv
// rtl/hilo_if.sv - handshake bus between hilo_unit and the iterative divider
interface hilo_if;
  logic        div_start;
  logic        div_signed;
  logic [31:0] div_dividend;
  logic [31:0] div_divisor;
  logic        div_ready;
  logic [31:0] div_quotient;
  logic [63:0] div_remainder;

  modport master (
    output div_start, div_signed, div_dividend, div_divisor,
    input  div_ready, div_quotient, div_remainder
  );

  modport slave (
    input  div_start, div_signed, div_dividend, div_divisor,
    output div_ready, div_quotient, div_remainder
  );
endinterface

// File: rtl/hilo_mul.sv
// rtl/hilo_mul.sv - registered 32x32 signed/unsigned multiplier, 64-bit product
module hilo_mul (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        is_signed,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] product
);

  logic [31:0] a_q, a_d, b_q, b_d;
  logic        is_signed_q, is_signed_d;
  logic [63:0] a_ext, b_ext;

  always_comb begin
    a_d         = load ? a : a_q;
    b_d         = load ? b : b_q;
    is_signed_d = load ? is_signed : is_signed_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q         <= '0;
      b_q         <= '0;
      is_signed_q <= 1'b0;
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      is_signed_q <= is_signed_d;
    end
  end

  // Low 64 bits of a sign/zero-extended product equal the true 64-bit result.
  always_comb begin
    a_ext   = {{32{is_signed_q & a_q[31]}}, a_q};
    b_ext   = {{32{is_signed_q & b_q[31]}}, b_q};
    product = a_ext * b_ext;
  end

endmodule

// File: rtl/hilo_unit.sv
// rtl/hilo_unit.sv - HI/LO registers and mul/div sequencer; HILO_MUL_EN enables MULT/MULTU
module hilo_unit
  import hilo_pkg::*;
#(
  parameter int DIV_TIMEOUT = 40
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  hilo_if.master      div_bus,
  output logic        stall,
  output logic [31:0] mf_data,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        dz_flag,
  output logic        timeout_flag
);

  localparam int CNT_W = $clog2(DIV_TIMEOUT);

  state_e      state_q, state_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] div_dividend_q, div_dividend_d, div_divisor_q, div_divisor_d;
  logic        div_signed_q, div_signed_d;
  logic        dz_flag_q, dz_flag_d, timeout_flag_q, timeout_flag_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        accept, is_div, wait_expired;
  logic        mul_load;
  logic [63:0] mul_product;
  logic        unused_rem_hi;
  op_e         op_c;

  assign op_c          = op_e'(op);
  assign accept        = op_valid && (state_q == ST_IDLE);
  assign is_div        = (op_c == OP_DIV) || (op_c == OP_DIVU);
  assign wait_expired  = (cnt_q == CNT_W'(DIV_TIMEOUT - 1));
  assign unused_rem_hi = ^div_bus.div_remainder[63:32];

`ifdef HILO_MUL_EN
  hilo_mul u_mul (
    .clk       (CLK),
    .rst_n     (RST),
    .load      (mul_load),
    .is_signed (op_c == OP_MULT),
    .a         (rs_val),
    .b         (rt_val),
    .product   (mul_product)
  );
`else
  assign mul_product = '0;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && is_div && (rt_val != '0)) state_d = ST_DIV_LAUNCH;
`ifdef HILO_MUL_EN
        if (accept && ((op_c == OP_MULT) || (op_c == OP_MULTU))) state_d = ST_MUL;
`endif
      end
      ST_DIV_LAUNCH: state_d = ST_DIV_WAIT;
      ST_DIV_WAIT:   if (div_bus.div_ready || wait_expired) state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    stall   = op_valid && (state_q != ST_IDLE);
    mf_data = '0;
    if (accept && (op_c == OP_MFHI)) mf_data = hi_q;
    if (accept && (op_c == OP_MFLO)) mf_data = lo_q;
  end

  always_comb begin
    hi_d           = hi_q;
    lo_d           = lo_q;
    div_dividend_d = div_dividend_q;
    div_divisor_d  = div_divisor_q;
    div_signed_d   = div_signed_q;
    dz_flag_d      = dz_flag_q;
    timeout_flag_d = timeout_flag_q;
    cnt_d          = cnt_q;
    mul_load       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (op_c)
            OP_DIV, OP_DIVU: begin
              if (rt_val == '0) begin
                dz_flag_d = 1'b1;
              end else begin
                div_dividend_d = rs_val;
                div_divisor_d  = rt_val;
                div_signed_d   = (op_c == OP_DIV);
              end
            end
            OP_MULT, OP_MULTU: mul_load = 1'b1;
            OP_MTHI: hi_d = rs_val;
            OP_MTLO: lo_d = rs_val;
            default: ;
          endcase
        end
      end
      ST_DIV_LAUNCH: cnt_d = '0;
      ST_DIV_WAIT: begin
        // A result on the last allowed cycle still wins over the timeout.
        if (div_bus.div_ready) begin
          lo_d = div_bus.div_quotient;
          hi_d = div_bus.div_remainder[31:0];
        end else if (wait_expired) begin
          timeout_flag_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef HILO_MUL_EN
      ST_MUL: {hi_d, lo_d} = mul_product;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      hi_q           <= '0;
      lo_q           <= '0;
      div_dividend_q <= '0;
      div_divisor_q  <= '0;
      div_signed_q   <= 1'b0;
      dz_flag_q      <= 1'b0;
      timeout_flag_q <= 1'b0;
      cnt_q          <= '0;
    end else begin
      hi_q           <= hi_d;
      lo_q           <= lo_d;
      div_dividend_q <= div_dividend_d;
      div_divisor_q  <= div_divisor_d;
      div_signed_q   <= div_signed_d;
      dz_flag_q      <= dz_flag_d;
      timeout_flag_q <= timeout_flag_d;
      cnt_q          <= cnt_d;
    end
  end

  assign div_bus.div_start    = (state_q == ST_DIV_LAUNCH);
  assign div_bus.div_signed   = div_signed_q;
  assign div_bus.div_dividend = div_dividend_q;
  assign div_bus.div_divisor  = div_divisor_q;
  assign hi           = hi_q;
  assign lo           = lo_q;
  assign dz_flag      = dz_flag_q;
  assign timeout_flag = timeout_flag_q;

endmodule

// File: tb/tb_hilo_unit.sv
// tb/tb_hilo_unit.sv - directed self-checking bench for hilo_unit with a behavioural divider
module tb_hilo_unit;
  import hilo_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] rs_val, rt_val;
  logic        stall;
  logic [31:0] mf_data, hi, lo;
  logic        dz_flag, timeout_flag;

  int errors = 0;
  int checks = 0;

  bit          model_en = 1'b1;
  int          cd = 0;
  logic [31:0] mq, mr;
  logic [31:0] exp_hi, exp_lo;

  hilo_if bus ();

  hilo_unit #(.DIV_TIMEOUT(40)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .op_valid     (op_valid),
    .op           (op),
    .rs_val       (rs_val),
    .rt_val       (rt_val),
    .div_bus      (bus),
    .stall        (stall),
    .mf_data      (mf_data),
    .hi           (hi),
    .lo           (lo),
    .dz_flag      (dz_flag),
    .timeout_flag (timeout_flag)
  );

  always #5 CLK = ~CLK;

  // Divider model: result pulse 34 edges after the start pulse; deliberately not reset.
  always @(posedge CLK) begin
    bus.div_ready <= 1'b0;
    if (bus.div_start) begin
      if (bus.div_signed) begin
        mq <= $signed(bus.div_dividend) / $signed(bus.div_divisor);
        mr <= $signed(bus.div_dividend) % $signed(bus.div_divisor);
      end else begin
        mq <= bus.div_dividend / bus.div_divisor;
        mr <= bus.div_dividend % bus.div_divisor;
      end
      cd <= 34;
    end else if (cd > 0) begin
      cd <= cd - 1;
      if (cd == 1 && model_en) begin
        bus.div_ready     <= 1'b1;
        bus.div_quotient  <= mq;
        bus.div_remainder <= {32'hDEAD_BEEF, mr};
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic present(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    op_valid = 1'b1;
    op       = o;
    rs_val   = a;
    rt_val   = b;
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b0; op_valid = 1'b0; op = '0; rs_val = '0; rt_val = '0;
    step(); step();
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h want 0", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo got %h want 0", lo); end
    checks++; if (mf_data !== 32'h0) begin errors++; $display("FAIL reset_mf got %h want 0", mf_data); end
    checks++; if ({stall, bus.div_start, bus.div_signed, dz_flag, timeout_flag} !== 5'b0) begin
      errors++; $display("FAIL reset_bits got %b want 00000", {stall, bus.div_start, bus.div_signed, dz_flag, timeout_flag});
    end
    checks++; if ({bus.div_dividend, bus.div_divisor} !== 64'h0) begin
      errors++; $display("FAIL reset_operands got %h want 0", {bus.div_dividend, bus.div_divisor});
    end
    RST = 1'b1;
    step();
  endtask

  task automatic test_mt_mf();
    present(OP_MTHI, 32'h1234, 32'h0);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mthi_stall got %b want 0", stall); end
    step();
    present(OP_MTLO, 32'hABCD, 32'h0);
    step();
    present(OP_MFHI, 32'h0, 32'h0);
    checks++; if (mf_data !== 32'h1234) begin errors++; $display("FAIL mfhi got %h want 1234", mf_data); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mfhi_stall got %b want 0", stall); end
    step();
    present(OP_MFLO, 32'h0, 32'h0);
    checks++; if (mf_data !== 32'hABCD) begin errors++; $display("FAIL mflo got %h want abcd", mf_data); end
    op_valid = 1'b0; #1;
    checks++; if (mf_data !== 32'h0) begin errors++; $display("FAIL mf_idle got %h want 0", mf_data); end
    step();
  endtask

  task automatic test_divu();
    int starts = 0;
    int stalled = 0;
    present(OP_DIVU, 32'd100, 32'd7);
    step();
    checks++; if ({bus.div_start, bus.div_signed} !== 2'b10) begin
      errors++; $display("FAIL divu_launch start/signed got %b want 10", {bus.div_start, bus.div_signed});
    end
    checks++; if ({bus.div_dividend, bus.div_divisor} !== {32'd100, 32'd7}) begin
      errors++; $display("FAIL divu_operands got %h want %h", {bus.div_dividend, bus.div_divisor}, {32'd100, 32'd7});
    end
    present(OP_MFLO, 32'h0, 32'h0);
    for (int i = 0; i < 80 && stall; i++) begin
      if (bus.div_start) starts++;
      stalled++;
      step();
    end
    checks++; if (starts !== 1) begin errors++; $display("FAIL divu_start_pulses got %0d want 1", starts); end
    checks++; if (stalled !== 36) begin errors++; $display("FAIL divu_stall_cycles got %0d want 36", stalled); end
    checks++; if (mf_data !== 32'd14) begin errors++; $display("FAIL divu_lo got %h want 0000000e", mf_data); end
    checks++; if (hi !== 32'd2) begin errors++; $display("FAIL divu_hi got %h want 2", hi); end
    op_valid = 1'b0;
    step();
  endtask

  task automatic test_div_signed();
    int stalled = 0;
    present(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    step();
    checks++; if (bus.div_signed !== 1'b1) begin errors++; $display("FAIL div_signed_sel got %b want 1", bus.div_signed); end
    present(OP_MFLO, 32'h0, 32'h0);
    for (int i = 0; i < 80 && stall; i++) begin
      stalled++;
      step();
    end
    checks++; if (stalled < 34) begin errors++; $display("FAIL div_mflo_stall got %0d want >=34", stalled); end
    checks++; if (mf_data !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo got %h want fffffffd", mf_data); end
    checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi got %h want ffffffff", hi); end
    op_valid = 1'b0;
    step();
  endtask

  task automatic test_div_zero();
    checks++; if (dz_flag !== 1'b0) begin errors++; $display("FAIL dz_before got %b want 0", dz_flag); end
    present(OP_DIV, 32'd55, 32'd0);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL dz_stall got %b want 0", stall); end
    step();
    checks++; if (dz_flag !== 1'b1) begin errors++; $display("FAIL dz_flag got %b want 1", dz_flag); end
    checks++; if (bus.div_start !== 1'b0) begin errors++; $display("FAIL dz_start got %b want 0", bus.div_start); end
    checks++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin
      errors++; $display("FAIL dz_hilo got %h want fffffffffffffffd", {hi, lo});
    end
    present(OP_MFHI, 32'h0, 32'h0);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL dz_next_stall got %b want 0", stall); end
    step();
  endtask

  task automatic test_mult();
    present(OP_MTHI, 32'h1111_1111, 32'h0); step();
    present(OP_MTLO, 32'h2222_2222, 32'h0); step();
    present(OP_MULT, 32'hFFFF_FFFF, 32'd2); step();
    present(OP_MFHI, 32'h0, 32'h0);
`ifdef HILO_MUL_EN
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL mult_stall got %b want 1", stall); end
    step();
    checks++; if (mf_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got %h want ffffffff", mf_data); end
    checks++; if (lo !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mult_lo got %h want fffffffe", lo); end
`else
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mult_nop_stall got %b want 0", stall); end
    checks++; if ({mf_data, lo} !== 64'h1111_1111_2222_2222) begin
      errors++; $display("FAIL mult_nop_hilo got %h want 1111111122222222", {mf_data, lo});
    end
`endif
    step();
    present(OP_MULTU, 32'hFFFF_FFFF, 32'd2); step();
    present(OP_MFLO, 32'h0, 32'h0);
`ifdef HILO_MUL_EN
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL multu_stall got %b want 1", stall); end
    step();
    checks++; if ({hi, mf_data} !== 64'h0000_0001_FFFF_FFFE) begin
      errors++; $display("FAIL multu_hilo got %h want 00000001fffffffe", {hi, mf_data});
    end
    exp_hi = 32'h0000_0001; exp_lo = 32'hFFFF_FFFE;
`else
    checks++; if ({hi, mf_data} !== 64'h1111_1111_2222_2222) begin
      errors++; $display("FAIL multu_nop_hilo got %h want 1111111122222222", {hi, mf_data});
    end
    exp_hi = 32'h1111_1111; exp_lo = 32'h2222_2222;
`endif
    op_valid = 1'b0;
    step();
  endtask

  task automatic test_timeout();
    int n = 0;
    model_en = 1'b0;
    present(OP_DIV, 32'd5, 32'd1);
    step();
    op_valid = 1'b0;
    while (!timeout_flag && n < 100) begin
      step();
      n++;
    end
    checks++; if (n !== 41) begin errors++; $display("FAIL timeout_latency got %0d want 41", n); end
    checks++; if ({hi, lo} !== {exp_hi, exp_lo}) begin
      errors++; $display("FAIL timeout_hilo got %h want %h", {hi, lo}, {exp_hi, exp_lo});
    end
    present(OP_MFHI, 32'h0, 32'h0);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL timeout_idle_stall got %b want 0", stall); end
    op_valid = 1'b0;
    model_en = 1'b1;
    step();
  endtask

  task automatic test_reset_mid_div();
    bit seen = 1'b0;
    present(OP_DIV, 32'd100, 32'd7);
    step();
    op_valid = 1'b0;
    repeat (10) step();
    RST = 1'b0;
    #1;
    checks++; if ({hi, lo, mf_data} !== 96'h0) begin errors++; $display("FAIL rst_mid_regs got %h want 0", {hi, lo, mf_data}); end
    checks++; if ({stall, bus.div_start, bus.div_signed, dz_flag, timeout_flag} !== 5'b0) begin
      errors++; $display("FAIL rst_mid_bits got %b want 00000", {stall, bus.div_start, bus.div_signed, dz_flag, timeout_flag});
    end
    checks++; if ({bus.div_dividend, bus.div_divisor} !== 64'h0) begin
      errors++; $display("FAIL rst_mid_operands got %h want 0", {bus.div_dividend, bus.div_divisor});
    end
    step();
    RST = 1'b1;
    for (int i = 0; i < 60 && !seen; i++) begin
      step();
      if (bus.div_ready) seen = 1'b1;
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL late_ready_seen got %b want 1", seen); end
    step();
    checks++; if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL late_ready_hilo got %h want 0", {hi, lo}); end
    present(OP_MFLO, 32'h0, 32'h0);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL late_ready_stall got %b want 0", stall); end
    op_valid = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_mt_mf();
    test_divu();
    test_div_signed();
    test_div_zero();
    test_mult();
    test_timeout();
    test_reset_mid_div();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
